// File: rtl/swdebounce_pkg.sv
// Shared definitions for the switch debouncer: state encoding, default sizing, counter-width helper.
// Latency: not applicable (declarations only).
// Backpressure: not applicable.
package swdebounce_pkg;

   // Per-bit debounce FSM states
   typedef enum logic {
      DB_IDLE   = 1'b0,
      DB_SETTLE = 1'b1
   } db_state_t;

   // Default hold time and the counter width that covers it
   localparam int DEF_TIMEOUT = 100000;
   localparam int DEF_CW      = 17;

   // Smallest counter width able to represent TIMEOUT (so 2**cw > timeout)
   function automatic int min_cw(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-FF synchronizer, IDLE/SETTLE FSM and hold counter.
// Latency: TIMEOUT+1 clocks from first sample of a held level to o_lvl.
// Backpressure: none; the bit free-runs and any return to the old level restarts the count.
module debounce_bit
   import swdebounce_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CW      = DEF_CW
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_sw,
   output logic o_lvl,
   output logic o_commit,
   output logic o_settle
);

   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          r_q1;
   logic          r_s;
   logic          r_out;
   db_state_t     r_state;
   logic [CW-1:0] r_cnt;

   db_state_t     w_state_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_out_nxt;
   logic          w_diff;
   logic          w_done;
   logic          w_commit;

   assign w_diff = (r_s != r_out);
   assign w_done = (r_cnt == CNT_LAST);

   // State register: synchronizer, FSM state, counter and accepted level
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_q1    <= 1'b0;
         r_s     <= 1'b0;
         r_out   <= 1'b0;
         r_state <= DB_IDLE;
         r_cnt   <= '0;
      end else begin
         r_q1    <= i_sw;
         r_s     <= r_q1;
         r_out   <= w_out_nxt;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state: start settling on a difference, abort on return, leave once the window expires
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         DB_IDLE: begin
            if (w_diff) begin
               w_state_nxt = DB_SETTLE;
               w_cnt_nxt   = CNT_ONE;
            end else begin
               w_cnt_nxt   = '0;
            end
         end
         DB_SETTLE: begin
            if (!w_diff || w_done) begin
               w_state_nxt = DB_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = DB_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs: commit only when the new level held through the full window
   always_comb begin
      w_commit  = (r_state == DB_SETTLE) && w_diff && w_done;
      w_out_nxt = w_commit ? r_s : r_out;
   end

   assign o_lvl    = r_out;
   assign o_commit = w_commit;
   assign o_settle = (r_state == DB_SETTLE);

endmodule

// File: rtl/swdebounce.sv
// Synchronizes and debounces the slide-switch bus, one independent debouncer per bit.
// Latency: TIMEOUT+1 clocks from first sample of a held level to o_sw / o_changed.
// Backpressure: none; o_changed pulses once per commit edge, o_busy flags any bit mid-settle.
module swdebounce
   import swdebounce_pkg::*;
#(
   parameter int NW      = 9,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CW      = DEF_CW
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic [NW-1:0] i_sw,
   output logic [NW-1:0] o_sw,
   output logic          o_changed,
   output logic          o_busy
);

   // Reject sizings where the counter cannot reach TIMEOUT-1 or the window is degenerate
   if ((TIMEOUT < 2) || (CW < min_cw(TIMEOUT))) begin : g_bad_param
      $error("swdebounce: need TIMEOUT >= 2 and 2**CW > TIMEOUT");
   end

   logic [NW-1:0] w_commit;
   logic [NW-1:0] w_settle;
   logic          r_changed;

   for (genvar k = 0; k < NW; k++) begin : g_bit
      debounce_bit #(
         .TIMEOUT (TIMEOUT),
         .CW      (CW)
      ) u_bit (
         .i_clk    (i_clk),
         .i_reset  (i_reset),
         .i_sw     (i_sw[k]),
         .o_lvl    (o_sw[k]),
         .o_commit (w_commit[k]),
         .o_settle (w_settle[k])
      );
   end

   // One pulse per commit edge, however many bits commit together
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_changed <= 1'b0;
      end else begin
         r_changed <= |w_commit;
      end
   end

   assign o_changed = r_changed;
   assign o_busy    = |w_settle;

endmodule

// File: tb/tb_swdebounce.sv
module tb_swdebounce;

   localparam int NW = 9;

   logic          clk;
   logic          rst;
   logic [NW-1:0] sw_in;
   logic [NW-1:0] sw_out;
   logic          changed;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   swdebounce #(
      .NW      (NW),
      .TIMEOUT (4),
      .CW      (3)
   ) dut (
      .i_clk     (clk),
      .i_reset   (rst),
      .i_sw      (sw_in),
      .o_sw      (sw_out),
      .o_changed (changed),
      .o_busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Advance one rising edge, then compare outputs 1 time unit later
   task automatic step(input string tag, input logic [NW-1:0] e_sw, input logic e_chg, input logic e_busy);
      @(posedge clk);
      #1;
      chk({tag, ".o_sw"}, sw_out, e_sw);
      chk({tag, ".o_changed"}, {8'd0, changed}, {8'd0, e_chg});
      chk({tag, ".o_busy"}, {8'd0, busy}, {8'd0, e_busy});
   endtask

   initial begin
      rst   = 1'b1;
      sw_in = 9'h1A5;
      // Reset held with switches up: everything stays cleared
      step("rst0", 9'h000, 1'b0, 1'b0);
      step("rst1", 9'h000, 1'b0, 1'b0);
      step("rst2", 9'h000, 1'b0, 1'b0);
      sw_in = 9'h000;
      step("rst3", 9'h000, 1'b0, 1'b0);
      rst = 1'b0;
      step("idle0", 9'h000, 1'b0, 1'b0);
      step("idle1", 9'h000, 1'b0, 1'b0);
      step("idle2", 9'h000, 1'b0, 1'b0);

      // Single bit rise: busy E+2..E+4, commit visible after E+5
      sw_in = 9'h001;
      step("one.E0", 9'h000, 1'b0, 1'b0);
      step("one.E1", 9'h000, 1'b0, 1'b0);
      step("one.E2", 9'h000, 1'b0, 1'b1);
      step("one.E3", 9'h000, 1'b0, 1'b1);
      step("one.E4", 9'h000, 1'b0, 1'b1);
      step("one.E5", 9'h001, 1'b1, 1'b0);
      step("one.E6", 9'h001, 1'b0, 1'b0);
      // Same bit falling back
      sw_in = 9'h000;
      step("onef.E0", 9'h001, 1'b0, 1'b0);
      step("onef.E1", 9'h001, 1'b0, 1'b0);
      step("onef.E2", 9'h001, 1'b0, 1'b1);
      step("onef.E3", 9'h001, 1'b0, 1'b1);
      step("onef.E4", 9'h001, 1'b0, 1'b1);
      step("onef.E5", 9'h000, 1'b1, 1'b0);
      step("onef.E6", 9'h000, 1'b0, 1'b0);

      // Glitch: bit 3 high for 3 samples, one short of acceptance
      sw_in = 9'h008;
      step("gl.E0", 9'h000, 1'b0, 1'b0);
      step("gl.E1", 9'h000, 1'b0, 1'b0);
      step("gl.E2", 9'h000, 1'b0, 1'b1);
      sw_in = 9'h000;
      step("gl.E3", 9'h000, 1'b0, 1'b1);
      step("gl.E4", 9'h000, 1'b0, 1'b1);
      step("gl.E5", 9'h000, 1'b0, 1'b0);
      step("gl.E6", 9'h000, 1'b0, 1'b0);
      step("gl.E7", 9'h000, 1'b0, 1'b0);

      // All bits together: one pulse
      sw_in = 9'h1FF;
      step("all.E0", 9'h000, 1'b0, 1'b0);
      step("all.E1", 9'h000, 1'b0, 1'b0);
      step("all.E2", 9'h000, 1'b0, 1'b1);
      step("all.E3", 9'h000, 1'b0, 1'b1);
      step("all.E4", 9'h000, 1'b0, 1'b1);
      step("all.E5", 9'h1FF, 1'b1, 1'b0);
      step("all.E6", 9'h1FF, 1'b0, 1'b0);
      sw_in = 9'h000;
      step("allf.E0", 9'h1FF, 1'b0, 1'b0);
      step("allf.E1", 9'h1FF, 1'b0, 1'b0);
      step("allf.E2", 9'h1FF, 1'b0, 1'b1);
      step("allf.E3", 9'h1FF, 1'b0, 1'b1);
      step("allf.E4", 9'h1FF, 1'b0, 1'b1);
      step("allf.E5", 9'h000, 1'b1, 1'b0);
      step("allf.E6", 9'h000, 1'b0, 1'b0);

      // Staggered: bit 0 at E, bit 8 at E+2; bit 8 still settling when bit 0 commits
      sw_in = 9'h001;
      step("stg.E0", 9'h000, 1'b0, 1'b0);
      step("stg.E1", 9'h000, 1'b0, 1'b0);
      sw_in = 9'h101;
      step("stg.E2", 9'h000, 1'b0, 1'b1);
      step("stg.E3", 9'h000, 1'b0, 1'b1);
      step("stg.E4", 9'h000, 1'b0, 1'b1);
      step("stg.E5", 9'h001, 1'b1, 1'b1);
      step("stg.E6", 9'h001, 1'b0, 1'b1);
      step("stg.E7", 9'h101, 1'b1, 1'b0);
      step("stg.E8", 9'h101, 1'b0, 1'b0);
      sw_in = 9'h000;
      step("stgf.E0", 9'h101, 1'b0, 1'b0);
      step("stgf.E1", 9'h101, 1'b0, 1'b0);
      step("stgf.E2", 9'h101, 1'b0, 1'b1);
      step("stgf.E3", 9'h101, 1'b0, 1'b1);
      step("stgf.E4", 9'h101, 1'b0, 1'b1);
      step("stgf.E5", 9'h000, 1'b1, 1'b0);
      step("stgf.E6", 9'h000, 1'b0, 1'b0);

      // Back-to-back commits: bit 1 at E, bit 2 at E+1 -> pulses after E+5 and E+6
      sw_in = 9'h002;
      step("b2b.E0", 9'h000, 1'b0, 1'b0);
      sw_in = 9'h006;
      step("b2b.E1", 9'h000, 1'b0, 1'b0);
      step("b2b.E2", 9'h000, 1'b0, 1'b1);
      step("b2b.E3", 9'h000, 1'b0, 1'b1);
      step("b2b.E4", 9'h000, 1'b0, 1'b1);
      step("b2b.E5", 9'h002, 1'b1, 1'b1);
      step("b2b.E6", 9'h006, 1'b1, 1'b0);
      step("b2b.E7", 9'h006, 1'b0, 1'b0);
      sw_in = 9'h000;
      step("b2bf.E0", 9'h006, 1'b0, 1'b0);
      step("b2bf.E1", 9'h006, 1'b0, 1'b0);
      step("b2bf.E2", 9'h006, 1'b0, 1'b1);
      step("b2bf.E3", 9'h006, 1'b0, 1'b1);
      step("b2bf.E4", 9'h006, 1'b0, 1'b1);
      step("b2bf.E5", 9'h000, 1'b1, 1'b0);
      step("b2bf.E6", 9'h000, 1'b0, 1'b0);

      // Reset mid-settle: asserted for edges E+3, E+4; R = E+5 restarts the full window
      sw_in = 9'h001;
      step("rms.E0", 9'h000, 1'b0, 1'b0);
      step("rms.E1", 9'h000, 1'b0, 1'b0);
      step("rms.E2", 9'h000, 1'b0, 1'b1);
      rst = 1'b1;
      step("rms.E3", 9'h000, 1'b0, 1'b0);
      step("rms.E4", 9'h000, 1'b0, 1'b0);
      rst = 1'b0;
      step("rms.R0", 9'h000, 1'b0, 1'b0);
      step("rms.R1", 9'h000, 1'b0, 1'b0);
      step("rms.R2", 9'h000, 1'b0, 1'b1);
      step("rms.R3", 9'h000, 1'b0, 1'b1);
      step("rms.R4", 9'h000, 1'b0, 1'b1);
      step("rms.R5", 9'h001, 1'b1, 1'b0);
      step("rms.R6", 9'h001, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
